exc_flow_ctrl: RTL and testbench
================================

# exc_flow_ctrl

Exception, interrupt and PC-flow controller for the single-cycle MIPS microsystem. Each cycle it decides the 3-bit next-PC select that drives the next-PC unit, merging the control unit's branch/jump request with synchronous exceptions, hardware and timer interrupts, and `eret`. It holds the CP0 state that this decision depends on (SR, Cause, EPC, Count/Compare, PRId) and serves the `mtc0`/`mfc0` accesses.

## Interface
- `PRID`, default 32'h0042_0001: read-only processor ID at CP0 register 15.
- `CMP_RST`, default 32'hFFFF_FFFF: reset value of Compare.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `pc` in 32: PC of the instruction currently executing.
- `pc_en` in 1: PC update enable. When 0 the instruction is held and does not commit.
- `br_sel` in 3: flow request from the control unit. 000 = seq, 001 = beq, 010 = j/jal, 011 = jr.
- `is_eret`, `is_syscall`, `ri`, `ovf` in 1 each: decode and ALU event flags for the current instruction.
- `hwint` in 6: asynchronous, level-sensitive hardware interrupt lines.
- `cp0_we` in 1: `mtc0` strobe.
- `cp0_addr` in 5: CP0 register number.
- `cp0_wdata` in 32: `mtc0` data.
- `npc_sel` out 3: select to the next-PC unit. 000 = seq, 001 = beq, 010 = jump, 011 = jr, 100 = EPC, 101 = vector 0x0000_4180.
- `epc_out` out 32: current EPC, feeds the next-PC unit's EPC input.
- `cp0_rdata` out 32: `mfc0` read data. Combinational from `cp0_addr`.
- `flush` out 1: suppresses register-file and memory writes of the current instruction.

## Operation
- Registers:
  - SR (12) = {16'b0, IM[7:0], 6'b0, EXL, IE}
  - Cause (13) = {16'b0, IP[7:0], 1'b0, ExcCode[4:0], 2'b00}
  - EPC (14)
  - Count (9)
  - Compare (11)
  - PRId (15)
  - Any other address reads 0 and ignores writes.
- IP[5:0] is the 2-flop-synchronized `hwint`, level (not sticky). IP[6] is always 0. IP[7] is the timer flag.
- Count increments by 1 every cycle, wrapping 0xFFFF_FFFF -> 0.
- When Count == Compare, IP[7] is set and stays set (sticky). A write to Compare clears IP[7].
- Interrupt-pending condition: int_pend = IE & ~EXL & |(IP & IM).
- Per-cycle decision, in priority order, evaluated only when `pc_en` = 1:
  1. `ri`: ExcCode 10.
  2. `is_syscall`: ExcCode 8.
  3. `ovf`: ExcCode 12.
  4. int_pend: ExcCode 0.
  5. `is_eret`.
  6. `br_sel`.
- For cases 1–4 (trap):
  - Outputs: `npc_sel` = 101, `flush` = 1.
  - State on the edge: EPC <= `pc`, ExcCode <= code, EXL <= 1.
  - Any same-cycle `cp0_we` is dropped.
  - A trap while EXL = 1 is taken anyway and overwrites EPC. Interrupts cannot fire while EXL = 1.
- Case 5 (`is_eret`): `npc_sel` = 100 and EXL <= 0 on the edge. If EXL is already 0 it stays 0; `npc_sel` is still 100.
- Case 6: `npc_sel` = `br_sel` and `flush` = 0. A `br_sel` value above 011 is forced to 000.
- `mtc0` with `cp0_we` = 1, `pc_en` = 1 and no trap:
  - Writes SR (IM, EXL, IE only), EPC, Count or Compare.
  - A write to Cause, PRId or an unmapped address is ignored.
  - A Count write overrides that cycle's increment.
- `pc_en` = 0:
  - `npc_sel` = `br_sel` (traps are not evaluated), `flush` = 0.
  - SR, Cause.ExcCode and EPC hold, and `mtc0` is ignored.
  - Count, the synchronizers and the timer compare keep running.
- Reset values:
  - SR = 0, ExcCode = 0, EPC = 0, Count = 0, Compare = `CMP_RST`.
  - IP[7] = 0 and both synchronizer stages = 0.
  - With `br_sel` = 000 and all event flags low: `npc_sel` = 000, `flush` = 0, `epc_out` = 0.
- Reset during a trap cycle: reset wins, and no EPC or EXL update occurs.

## Timing
- `npc_sel`, `flush` and `cp0_rdata` are combinational. Their only registered inputs are CP0 state.
- `hwint` asserted before edge N is in sync stage 2 after edge N+1, so IP is visible in cycle N+1 and the earliest interrupt trap is in cycle N+1.
- Timer: if Count == Compare in cycle K, IP[7] = 1 from cycle K+1, and the earliest timer trap is in cycle K+1.
- `mtc0` to SR/EPC/Compare in cycle K takes effect from cycle K+1. An `mfc0` in cycle K returns the old value.
- After a trap in cycle K: EXL = 1 and EPC = `pc`(K) from cycle K+1.
- After `eret` in cycle K: EXL = 0 from cycle K+1. A pending interrupt can then trap in cycle K+1.

## Test plan
- Reset, then `br_sel` = 001, then 011: `npc_sel` is 001 then 011; `flush` = 0; `cp0_rdata` at address 15 = 32'h0042_0001.
- `mtc0` SR = 32'h0000_0401 (IM[2], IE), `pc` = 0x3010, `hwint[2]` raised at edge N: `npc_sel` = 101 and `flush` = 1 in cycle N+1; then EPC = 0x3010, ExcCode = 0, EXL = 1, and no second trap while `hwint` stays high.
- `is_syscall` and `ovf` together at `pc` = 0x3020: ExcCode = 8, EPC = 0x3020. Next cycle `is_eret`: `npc_sel` = 100, `epc_out` = 0x3020, EXL = 0 afterwards.
- Compare = 5, Count = 0, IM[7] = 1, IE = 1: IP[7] sets after Count reaches 5 and the trap follows. Writing Compare clears IP[7].
- `ri` with `pc_en` = 0 for 3 cycles: no trap and EPC unchanged. On `pc_en` = 1 the trap is taken.
- Trap and `mtc0` EPC = 0x1234 in the same cycle: EPC = `pc`, and the `mtc0` is dropped.

Source files
------------

// File: rtl/exc_flow_ctrl.sv
// exc_flow_ctrl: next-PC selection, trap/interrupt handling and CP0 state
// (SR, Cause, EPC, Count, Compare, PRId) for the single-cycle MIPS core.
module exc_flow_ctrl #(
  parameter logic [31:0] PRID    = 32'h0042_0001,
  parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pc_en,
  input  logic [2:0]  br_sel,
  input  logic        is_eret,
  input  logic        is_syscall,
  input  logic        ri,
  input  logic        ovf,
  input  logic [5:0]  hwint,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [2:0]  npc_sel,
  output logic [31:0] epc_out,
  output logic [31:0] cp0_rdata,
  output logic        flush
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OVF = 5'd12;

  localparam logic [2:0] NPC_SEQ = 3'b000;
  localparam logic [2:0] NPC_JR  = 3'b011;
  localparam logic [2:0] NPC_EPC = 3'b100;
  localparam logic [2:0] NPC_VEC = 3'b101;

  logic [5:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tip_q, tip_d;

  logic [7:0]  ip;
  logic        int_pend;
  logic        trap;
  logic [4:0]  trap_code;
  logic [2:0]  br_safe;
  logic        wr_en;

  assign epc_out = epc_q;

  // Flow decision: prioritised trap detection, then eret, then the branch request.
  always_comb begin
    ip        = {tip_q, 1'b0, sync2_q};
    int_pend  = ie_q & ~exl_q & (|(ip & im_q));
    br_safe   = (br_sel > NPC_JR) ? NPC_SEQ : br_sel;
    trap      = 1'b0;
    trap_code = EXC_INT;
    if (pc_en) begin
      if (ri) begin
        trap      = 1'b1;
        trap_code = EXC_RI;
      end else if (is_syscall) begin
        trap      = 1'b1;
        trap_code = EXC_SYS;
      end else if (ovf) begin
        trap      = 1'b1;
        trap_code = EXC_OVF;
      end else if (int_pend) begin
        trap      = 1'b1;
        trap_code = EXC_INT;
      end
    end
    flush = trap;
    if (trap) begin
      npc_sel = NPC_VEC;
    end else if (pc_en && is_eret) begin
      npc_sel = NPC_EPC;
    end else begin
      npc_sel = br_safe;
    end
  end

  // CP0 next state: free-running count/timer/synchronisers, then mtc0, trap and eret effects.
  always_comb begin
    wr_en      = cp0_we & pc_en & ~trap;
    sync1_d    = hwint;
    sync2_d    = sync1_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    count_d    = count_q + 32'd1;
    compare_d  = compare_q;
    tip_d      = tip_q | (count_q == compare_q);
    if (wr_en) begin
      case (cp0_addr)
        ADDR_COUNT:   count_d = cp0_wdata;
        ADDR_COMPARE: begin
          compare_d = cp0_wdata;
          tip_d     = 1'b0;
        end
        ADDR_SR: begin
          im_d  = cp0_wdata[15:8];
          exl_d = cp0_wdata[1];
          ie_d  = cp0_wdata[0];
        end
        ADDR_EPC:     epc_d = cp0_wdata;
        default:      ;
      endcase
    end
    if (trap) begin
      epc_d      = pc;
      exc_code_d = trap_code;
      exl_d      = 1'b1;
    end else if (pc_en && is_eret) begin
      exl_d = 1'b0;
    end
  end

  // mfc0 read mux; unmapped addresses read as zero.
  always_comb begin
    case (cp0_addr)
      ADDR_COUNT:   cp0_rdata = count_q;
      ADDR_COMPARE: cp0_rdata = compare_q;
      ADDR_SR:      cp0_rdata = {16'b0, im_q, 6'b0, exl_q, ie_q};
      ADDR_CAUSE:   cp0_rdata = {16'b0, ip, 1'b0, exc_code_q, 2'b00};
      ADDR_EPC:     cp0_rdata = epc_q;
      ADDR_PRID:    cp0_rdata = PRID;
      default:      cp0_rdata = 32'd0;
    endcase
  end

  // CP0 state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 6'd0;
      sync2_q    <= 6'd0;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= CMP_RST;
      tip_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      tip_q      <= tip_d;
    end
  end

endmodule

// File: tb/tb_exc_flow_ctrl.sv
// tb_exc_flow_ctrl: directed and randomized stimulus for exc_flow_ctrl, with a
// behavioural CP0 model feeding an expectation queue drained by a monitor.
module tb_exc_flow_ctrl;

  localparam logic [31:0] PRID_V = 32'h0042_0001;
  localparam logic [31:0] CMP_V  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_en;
  logic [2:0]  br_sel;
  logic        is_eret, is_syscall, ri, ovf;
  logic [5:0]  hwint;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [2:0]  npc_sel;
  logic [31:0] epc_out;
  logic [31:0] cp0_rdata;
  logic        flush;

  exc_flow_ctrl #(.PRID(PRID_V), .CMP_RST(CMP_V)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_en(pc_en), .br_sel(br_sel),
    .is_eret(is_eret), .is_syscall(is_syscall), .ri(ri), .ovf(ovf),
    .hwint(hwint), .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .npc_sel(npc_sel), .epc_out(epc_out), .cp0_rdata(cp0_rdata), .flush(flush)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pc_en;
    logic [2:0]  br;
    logic        eret, sys, ri, ovf;
    logic [5:0]  hw;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } stim_t;

  typedef struct {
    int          cyc;
    logic [2:0]  npc;
    logic        flush;
    logic [31:0] epc;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;
  int   cyc       = 0;

  // Architectural CP0 view kept by the bench.
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_tip;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_count, m_compare;
  logic [5:0]  m_hw[$];
  logic [5:0]  rnd_hw = 6'd0;

  task automatic modelReset();
    m_im = 8'd0; m_exl = 1'b0; m_ie = 1'b0; m_tip = 1'b0; m_code = 5'd0;
    m_epc = 32'd0; m_count = 32'd0; m_compare = CMP_V;
    m_hw.delete();
    m_hw.push_back(6'd0);
    m_hw.push_back(6'd0);
  endtask

  // Interrupt lines become visible two cycles after they are driven.
  function automatic logic [7:0] modelIp();
    return {m_tip, 1'b0, m_hw[0]};
  endfunction

  function automatic logic modelTrap(input stim_t s, output logic [4:0] code);
    code = 5'd0;
    if (!s.pc_en) return 1'b0;
    if (s.ri)  begin code = 5'd10; return 1'b1; end
    if (s.sys) begin code = 5'd8;  return 1'b1; end
    if (s.ovf) begin code = 5'd12; return 1'b1; end
    if (m_ie && !m_exl && ((modelIp() & m_im) != 8'd0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t modelOutputs(input stim_t s);
    exp_t e;
    logic [4:0] code;
    logic t;
    t = modelTrap(s, code);
    e.cyc   = cyc;
    e.flush = t;
    e.epc   = m_epc;
    if (t)                      e.npc = 3'd5;
    else if (s.pc_en && s.eret) e.npc = 3'd4;
    else if (s.br > 3'd3)       e.npc = 3'd0;
    else                        e.npc = s.br;
    case (s.addr)
      5'd9:    e.rdata = m_count;
      5'd11:   e.rdata = m_compare;
      5'd12:   e.rdata = {16'd0, m_im, 6'd0, m_exl, m_ie};
      5'd13:   e.rdata = {16'd0, modelIp(), 1'b0, m_code, 2'b00};
      5'd14:   e.rdata = m_epc;
      5'd15:   e.rdata = PRID_V;
      default: e.rdata = 32'd0;
    endcase
    return e;
  endfunction

  task automatic modelStep(input stim_t s);
    logic [4:0] code;
    logic t, wr, hit;
    t   = modelTrap(s, code);
    wr  = s.we && s.pc_en && !t;
    hit = (m_count == m_compare);
    m_count = m_count + 32'd1;
    m_tip   = m_tip | hit;
    if (wr && s.addr == 5'd9) m_count = s.wdata;
    if (wr && s.addr == 5'd11) begin
      m_compare = s.wdata;
      m_tip     = 1'b0;
    end
    if (t) begin
      m_epc = s.pc; m_code = code; m_exl = 1'b1;
    end else if (s.pc_en) begin
      if (wr && s.addr == 5'd12) begin
        m_im = s.wdata[15:8]; m_exl = s.wdata[1]; m_ie = s.wdata[0];
      end
      if (wr && s.addr == 5'd14) m_epc = s.wdata;
      if (s.eret) m_exl = 1'b0;
    end
    void'(m_hw.pop_front());
    m_hw.push_back(s.hw);
  endtask

  function automatic stim_t idleStim(input logic [31:0] p, input logic [4:0] a);
    stim_t s;
    s.rst = 1'b0; s.pc_en = 1'b1; s.br = 3'd0; s.eret = 1'b0; s.sys = 1'b0;
    s.ri = 1'b0; s.ovf = 1'b0; s.hw = 6'd0; s.we = 1'b0; s.addr = a;
    s.wdata = 32'd0; s.pc = p;
    return s;
  endfunction

  // Drive one cycle just after the rising edge and queue the expected response.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    reset = s.rst; pc = s.pc; pc_en = s.pc_en; br_sel = s.br;
    is_eret = s.eret; is_syscall = s.sys; ri = s.ri; ovf = s.ovf;
    hwint = s.hw; cp0_we = s.we; cp0_addr = s.addr; cp0_wdata = s.wdata;
    cyc++;
    if (s.rst) begin
      modelReset();
    end else begin
      exp_q.push_back(modelOutputs(s));
      modelStep(s);
    end
  endtask

  task automatic checkOutput(input string name, input int c, input logic [31:0] got,
                             input logic [31:0] want);
    check_cnt++;
    if (got === want) pass_cnt++;
    else $display("[TB] FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
  endtask

  function automatic stim_t makeRandom();
    stim_t s;
    logic [4:0] addr_tab [8];
    addr_tab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd7};
    s = idleStim({$urandom} & 32'hFFFF_FFFC, addr_tab[$urandom_range(0, 7)]);
    s.pc_en = ($urandom_range(0, 7) != 0);
    s.br    = s.pc_en ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
    s.ri    = ($urandom_range(0, 19) == 0);
    s.sys   = ($urandom_range(0, 19) == 0);
    s.ovf   = ($urandom_range(0, 19) == 0);
    s.eret  = ($urandom_range(0, 7) == 0);
    if ($urandom_range(0, 5) == 0) rnd_hw[$urandom_range(0, 5)] = ~rnd_hw[$urandom_range(0, 5)];
    s.hw    = rnd_hw;
    s.we    = !s.eret && ($urandom_range(0, 2) == 0);
    s.wdata = $urandom;
    if (s.addr == 5'd11 && $urandom_range(0, 1) == 1) s.wdata = m_count + $urandom_range(2, 20);
    if (s.addr == 5'd12) s.wdata[1] = ($urandom_range(0, 3) == 0);
    s.rst   = ($urandom_range(0, 199) == 0);
    return s;
  endfunction

  // Monitor: every falling edge, compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("npc_sel",   e.cyc, {29'd0, npc_sel}, {29'd0, e.npc});
        checkOutput("flush",     e.cyc, {31'd0, flush},   {31'd0, e.flush});
        checkOutput("epc_out",   e.cyc, epc_out,          e.epc);
        checkOutput("cp0_rdata", e.cyc, cp0_rdata,        e.rdata);
      end
    end
  end

  // Stimulus: directed scenarios first, then a randomized run.
  initial begin
    stim_t s;
    int waited;
    reset = 1'b1; pc = 32'd0; pc_en = 1'b0; br_sel = 3'd0; is_eret = 1'b0;
    is_syscall = 1'b0; ri = 1'b0; ovf = 1'b0; hwint = 6'd0; cp0_we = 1'b0;
    cp0_addr = 5'd0; cp0_wdata = 32'd0;
    modelReset();

    s = idleStim(32'd0, 5'd0); s.rst = 1'b1;
    applyStimulus(s); applyStimulus(s);
    s = idleStim(32'h3000, 5'd12); applyStimulus(s);
    s = idleStim(32'h3000, 5'd15); s.br = 3'b001; applyStimulus(s);
    s.br = 3'b011; applyStimulus(s);

    s = idleStim(32'h3004, 5'd12); s.we = 1'b1; s.wdata = 32'h0000_0401; applyStimulus(s);
    for (int i = 0; i < 6; i++) begin
      s = idleStim(32'h3010, (i % 2 == 1) ? 5'd14 : 5'd13); s.hw = 6'b000100; applyStimulus(s);
    end
    for (int i = 0; i < 3; i++) begin
      s = idleStim(32'h3014, 5'd12); applyStimulus(s);
    end
    s = idleStim(32'h3018, 5'd12); s.eret = 1'b1; applyStimulus(s);

    s = idleStim(32'h3020, 5'd13); s.sys = 1'b1; s.ovf = 1'b1; applyStimulus(s);
    s = idleStim(32'h4180, 5'd14); s.eret = 1'b1; applyStimulus(s);
    s = idleStim(32'h3020, 5'd12); applyStimulus(s);

    s = idleStim(32'h3100, 5'd11); s.we = 1'b1; s.wdata = 32'd5; applyStimulus(s);
    s = idleStim(32'h3104, 5'd12); s.we = 1'b1; s.wdata = 32'h0000_8001; applyStimulus(s);
    s = idleStim(32'h3108, 5'd9);  s.we = 1'b1; s.wdata = 32'd0; applyStimulus(s);
    for (int i = 0; i < 10; i++) begin
      s = idleStim(32'h310C, (i % 2 == 1) ? 5'd9 : 5'd13); applyStimulus(s);
    end
    s = idleStim(32'h4180, 5'd11); s.we = 1'b1; s.wdata = 32'hFFFF_FFFF; applyStimulus(s);
    s = idleStim(32'h4184, 5'd13); s.eret = 1'b1; applyStimulus(s);
    s = idleStim(32'h3110, 5'd13); applyStimulus(s); applyStimulus(s);

    for (int i = 0; i < 3; i++) begin
      s = idleStim(32'h3030, 5'd14); s.pc_en = 1'b0; s.ri = 1'b1; applyStimulus(s);
    end
    s = idleStim(32'h3030, 5'd13); s.ri = 1'b1; applyStimulus(s);
    s = idleStim(32'h4180, 5'd14); s.eret = 1'b1; applyStimulus(s);

    s = idleStim(32'h3040, 5'd14); s.ri = 1'b1; s.we = 1'b1; s.wdata = 32'h1234; applyStimulus(s);
    s = idleStim(32'h4180, 5'd14); applyStimulus(s);

    s = idleStim(32'h3050, 5'd14); s.rst = 1'b1; s.ri = 1'b1; applyStimulus(s);
    s = idleStim(32'h3054, 5'd14); applyStimulus(s);
    s = idleStim(32'h3058, 5'd12); applyStimulus(s);

    for (int i = 0; i < 600; i++) applyStimulus(makeRandom());

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      check_cnt++;
      $display("[TB] FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
